// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: accepts one core request, issues one word-aligned bus access, returns a sign/zero-extended load result.
// Latency is N+2 when mem_ready is held high. The core is stalled until done, and a bus that never answers is aborted after TIMEOUT_CYCLES.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mem_valid;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_done;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [2:0]    r_func3;
    logic [1:0]    r_lane;

    logic          w_misalign;
    logic          w_bad_f3;
    logic          w_illegal;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        w_misalign = 1'b0;
        case (req_func3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
        // Loads allow the unsigned byte/half encodings (100, 101); stores do not.
        if (req_write)
            w_bad_f3 = req_func3[2] | (req_func3[1:0] == 2'b11);
        else
            w_bad_f3 = (req_func3[1:0] == 2'b11) | (req_func3 == 3'b110);
        w_illegal = w_bad_f3 | w_misalign;
    end

    always_comb begin
        w_wdata = req_wdata;
        w_wstrb = 4'b1111;
        case (req_func3[1:0])
            2'b00: begin
                w_wdata = {4{req_wdata[7:0]}};
                w_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{req_wdata[15:0]}};
                w_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                w_wdata = req_wdata;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!req_write)
            w_wstrb = 4'b0000;
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_func3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_func3     <= 3'd0;
            r_lane      <= 2'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_cnt       <= '0;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_write;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= w_wstrb;
                            r_func3     <= req_func3;
                            r_lane      <= req_addr[1:0];
                        end
                    end
                end
                S_REQ: begin
                    // A late mem_ready wins over a timeout expiring in the same cycle.
                    if (mem_ready) begin
                        r_state     <= S_RESP;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                        if (!r_mem_we)
                            r_rdata <= w_load;
                    end else if (w_cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        r_state     <= S_ERR;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall     = req_valid & ~r_done;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: default-timeout instance for bus traffic, TIMEOUT_CYCLES=4 instance for abort cases.
module tb_lsu_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_valid_to;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        stall, done, err, mem_valid, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        to_stall, to_done, to_err, to_mem_valid, to_mem_we;
    logic [31:0] to_rdata, to_mem_addr, to_mem_wdata;
    logic [3:0]  to_mem_wstrb;

    int n_total = 0;
    int n_pass  = 0;

    lsu_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .err(err), .rdata(rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_to), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(to_stall), .done(to_done), .err(to_err), .rdata(to_rdata),
        .mem_valid(to_mem_valid), .mem_ready(mem_ready), .mem_we(to_mem_we),
        .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata), .mem_wstrb(to_mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        req_write = wr;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    initial begin
        int mv_cnt;
        int k;
        logic stall_dropped;

        rst_n = 1'b0; req_valid = 1'b0; req_valid_to = 1'b0;
        set_req(1'b0, 3'b000, 32'd0, 32'd0);
        mem_ready = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_rdata",     rdata,              32'd0);
        check("rst_wstrb",     {28'd0, mem_wstrb}, 32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);

        // SB presented in the very cycle reset is released
        rst_n = 1'b1;
        set_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        mem_ready = 1'b1; req_valid = 1'b1;
        #1;
        check("sb_stall_n", {31'd0, stall}, 32'd1);
        tick();
        check("sb_mv_n1",  {31'd0, mem_valid}, 32'd1);
        check("sb_we",     {31'd0, mem_we},    32'd1);
        check("sb_addr",   mem_addr,           32'h0000_1000);
        check("sb_wdata",  mem_wdata,          32'hABAB_ABAB);
        check("sb_wstrb",  {28'd0, mem_wstrb}, 32'h8);
        check("sb_done_n1",{31'd0, done},      32'd0);
        tick();
        check("sb_done_n2",{31'd0, done},      32'd1);
        check("sb_err",    {31'd0, err},       32'd0);
        check("sb_mv_n2",  {31'd0, mem_valid}, 32'd0);
        check("sb_stall",  {31'd0, stall},     32'd0);
        req_valid = 1'b0;
        tick();
        check("sb_done_off", {31'd0, done}, 32'd0);

        // LB then LBU at the same byte lane
        set_req(1'b0, 3'b000, 32'h0000_2001, 32'd0);
        mem_rdata = 32'h0000_80FF; req_valid = 1'b1;
        tick();
        check("lb_wstrb", {28'd0, mem_wstrb}, 32'h0);
        check("lb_we",    {31'd0, mem_we},    32'd0);
        tick();
        check("lb_done",  {31'd0, done}, 32'd1);
        check("lb_rdata", rdata,         32'hFFFF_FF80);
        req_valid = 1'b0;
        tick();
        set_req(1'b0, 3'b100, 32'h0000_2001, 32'd0);
        req_valid = 1'b1;
        tick(); tick();
        check("lbu_done",  {31'd0, done}, 32'd1);
        check("lbu_rdata", rdata,         32'h0000_0080);
        req_valid = 1'b0;
        tick();

        // LH with mem_ready held off for 5 REQ cycles
        set_req(1'b0, 3'b001, 32'h0000_2002, 32'd0);
        mem_rdata = 32'h8001_1234; mem_ready = 1'b0; req_valid = 1'b1;
        mv_cnt = 0; stall_dropped = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (mem_valid) mv_cnt++;
            if (!stall) stall_dropped = 1'b1;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_valid) mv_cnt++;
        if (!stall) stall_dropped = 1'b1;
        check("lh_addr_held", mem_addr, 32'h0000_2000);
        tick();
        check("lh_mv_cycles", mv_cnt,                  6);
        check("lh_stall_held",{31'd0, stall_dropped},  32'd0);
        check("lh_done",      {31'd0, done},           32'd1);
        check("lh_mv_off",    {31'd0, mem_valid},      32'd0);
        check("lh_rdata",     rdata,                   32'hFFFF_8001);
        req_valid = 1'b0;
        tick();

        // Misaligned LW: immediate error, no bus access
        set_req(1'b0, 3'b010, 32'h0000_3002, 32'd0);
        req_valid = 1'b1;
        #1;
        check("lw_mis_mv0", {31'd0, mem_valid}, 32'd0);
        tick();
        check("lw_mis_done", {31'd0, done},      32'd1);
        check("lw_mis_err",  {31'd0, err},       32'd1);
        check("lw_mis_mv1",  {31'd0, mem_valid}, 32'd0);
        req_valid = 1'b0;
        tick();
        check("lw_mis_err_off", {31'd0, err}, 32'd0);
        check("lw_mis_rdata",   rdata,        32'hFFFF_8001);

        // Store with func3=100 is illegal
        set_req(1'b1, 3'b100, 32'h0000_3000, 32'h1111_1111);
        req_valid = 1'b1;
        tick();
        check("st_f3_err", {31'd0, err},       32'd1);
        check("st_f3_mv",  {31'd0, mem_valid}, 32'd0);
        req_valid = 1'b0;
        tick();

        // Timeout on the TIMEOUT_CYCLES=4 instance
        set_req(1'b0, 3'b010, 32'h0000_4000, 32'd0);
        mem_ready = 1'b0; req_valid_to = 1'b1;
        mv_cnt = 0; k = 0;
        tick();
        while (!to_done && k < 20) begin
            if (to_mem_valid) mv_cnt++;
            k++;
            tick();
        end
        check("to_seen",      {31'd0, to_done},      32'd1);
        check("to_mv_cycles", mv_cnt,                4);
        check("to_err",       {31'd0, to_err},       32'd1);
        check("to_mv_off",    {31'd0, to_mem_valid}, 32'd0);
        req_valid_to = 1'b0;
        tick();

        // mem_ready in the expiring cycle takes priority
        mem_rdata = 32'h1234_5678; req_valid_to = 1'b1;
        tick(); tick(); tick(); tick();
        mem_ready = 1'b1;
        tick();
        check("to_prio_done",  {31'd0, to_done}, 32'd1);
        check("to_prio_err",   {31'd0, to_err},  32'd0);
        check("to_prio_rdata", to_rdata,         32'h1234_5678);
        req_valid_to = 1'b0;
        tick();

        // Reset on the third REQ cycle
        set_req(1'b0, 3'b010, 32'h0000_5000, 32'd0);
        mem_ready = 1'b0; req_valid = 1'b1;
        tick(); tick(); tick();
        check("rr_mv_before", {31'd0, mem_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("rr_mv",    {31'd0, mem_valid}, 32'd0);
        check("rr_done",  {31'd0, done},      32'd0);
        check("rr_rdata", rdata,              32'd0);
        rst_n = 1'b1; req_valid = 1'b0;
        tick();

        set_req(1'b1, 3'b010, 32'h0000_6004, 32'hDEAD_BEEF);
        mem_ready = 1'b1; req_valid = 1'b1;
        tick();
        check("sw_addr",  mem_addr,           32'h0000_6004);
        check("sw_wdata", mem_wdata,          32'hDEAD_BEEF);
        check("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        tick();
        check("sw_done",  {31'd0, done}, 32'd1);
        check("sw_err",   {31'd0, err},  32'd0);
        req_valid = 1'b0;
        tick();

        // SH to the upper halfword
        set_req(1'b1, 3'b001, 32'h0000_7002, 32'h1234_CAFE);
        req_valid = 1'b1;
        tick();
        check("sh_wdata", mem_wdata,          32'hCAFE_CAFE);
        check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        check("sh_addr",  mem_addr,           32'h0000_7000);
        tick();
        check("sh_done",  {31'd0, done}, 32'd1);
        req_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
